iu_warp_scheduler: RTL and testbench

IU_WARP_SCHEDULER -- requirements
Module: iu_warp_scheduler

---
 rtl/iu_warp_scheduler_pkg.sv | 21 ++
 rtl/iu_warp_scheduler_if.sv | 60 ++++++
 rtl/iu_warp_scheduler_rr_arbiter.sv | 31 +++
 rtl/iu_warp_scheduler.sv | 116 +++++++++++
 tb/tb_iu_warp_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/iu_warp_scheduler_pkg.sv
// Shared GPU issue-unit definitions: warp count,
// warp lifecycle encoding and pointer helper.
package iu_warp_scheduler_pkg;

  localparam int NUM_WARPS    = 8;
  localparam int LOGNUM_WARPS = 3;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_ACTIVE  = 2'd1,
    W_BR_WAIT = 2'd2
  } warp_state_e;

  // Warp count is a power of two, so the
  // pointer wraps by plain overflow.
  function automatic logic [LOGNUM_WARPS-1:0]
    nxt_ptr(input logic [LOGNUM_WARPS-1:0] g);
    return g + LOGNUM_WARPS'(1);
  endfunction

endpackage

// File: rtl/iu_warp_scheduler_if.sv
// Issue-unit bundle: IB/SB/OC/RAU/SIMT side
// signals around the warp scheduler.
interface iu_warp_scheduler_if
  import iu_warp_scheduler_pkg::*;
#(
  parameter int NW = NUM_WARPS,
  parameter int LW = LOGNUM_WARPS
) ();

  logic [NW-1:0] req_IB_IU;
  logic [NW-1:0] ready_SB_IU;
  logic [NW-1:0] branch_IB_IU;
  logic [NW-1:0] exit_IB_IU;
  logic          full_OC_IU;
  logic          start_RAU_IU;
  logic [LW-1:0] start_warpID_RAU_IU;
  logic          resolve_SIMT_IU;
  logic [LW-1:0] resolve_warpID_SIMT_IU;

  logic [NW-1:0] grt_IU_IB;
  logic          valid_IU_OC;
  logic [LW-1:0] warpID_IU_OC;
  logic          exit_IU_RAU;
  logic [LW-1:0] warpID_IU_RAU;

  modport master (
    output req_IB_IU,
    output ready_SB_IU,
    output branch_IB_IU,
    output exit_IB_IU,
    output full_OC_IU,
    output start_RAU_IU,
    output start_warpID_RAU_IU,
    output resolve_SIMT_IU,
    output resolve_warpID_SIMT_IU,
    input  grt_IU_IB,
    input  valid_IU_OC,
    input  warpID_IU_OC,
    input  exit_IU_RAU,
    input  warpID_IU_RAU
  );

  modport slave (
    input  req_IB_IU,
    input  ready_SB_IU,
    input  branch_IB_IU,
    input  exit_IB_IU,
    input  full_OC_IU,
    input  start_RAU_IU,
    input  start_warpID_RAU_IU,
    input  resolve_SIMT_IU,
    input  resolve_warpID_SIMT_IU,
    output grt_IU_IB,
    output valid_IU_OC,
    output warpID_IU_OC,
    output exit_IU_RAU,
    output warpID_IU_RAU
  );

endinterface

// File: rtl/iu_warp_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first
// requester at or after the pointer wins.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int LW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [LW-1:0] idx_o,
  output logic          vld_o
);

  logic [LW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = ptr_i + LW'(i);
      if (!vld_o && req_i[k]) begin
        vld_o    = 1'b1;
        idx_o    = k;
        gnt_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iu_warp_scheduler.sv
// Warp issue scheduler: tracks warp lifecycle,
// grants one eligible warp per cycle round-robin.
module iu_warp_scheduler
  import iu_warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS =
    iu_warp_scheduler_pkg::NUM_WARPS,
  parameter int LOGNUM_WARPS =
    iu_warp_scheduler_pkg::LOGNUM_WARPS
) (
  input  logic clk,
  input  logic rst,
  iu_warp_scheduler_if.slave bus
);

  localparam int N  = NUM_WARPS;
  localparam int LW = LOGNUM_WARPS;

  warp_state_e   state_q [N];
  warp_state_e   state_d [N];
  logic [LW-1:0] rr_ptr_q, rr_ptr_d;

  logic          valid_q, valid_d;
  logic [LW-1:0] oc_id_q, oc_id_d;
  logic          exit_q,  exit_d;
  logic [LW-1:0] rau_id_q, rau_id_d;

  logic [N-1:0]  elig;
  logic [N-1:0]  arb_req;
  logic [N-1:0]  gnt;
  logic [LW-1:0] gidx;
  logic          gvld;

  always_comb begin
    elig = '0;
    for (int w = 0; w < N; w++) begin
      elig[w] = (state_q[w] == W_ACTIVE)
              & bus.req_IB_IU[w]
              & bus.ready_SB_IU[w];
    end
  end

  // Reset also masks the grant so no IB pops.
  assign arb_req =
    (rst || bus.full_OC_IU) ? '0 : elig;

  rr_arbiter #(
    .N  (N),
    .LW (LW)
  ) u_arb (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .vld_o (gvld)
  );

  assign bus.grt_IU_IB = gnt;

  always_comb begin
    for (int w = 0; w < N; w++) begin
      state_d[w] = state_q[w];
      unique case (1'b1)
        gnt[w]: begin
          if (bus.exit_IB_IU[w])
            state_d[w] = W_IDLE;
          else if (bus.branch_IB_IU[w])
            state_d[w] = W_BR_WAIT;
        end
        bus.start_RAU_IU
          && bus.start_warpID_RAU_IU == LW'(w)
          && state_q[w] == W_IDLE:
          state_d[w] = W_ACTIVE;
        bus.resolve_SIMT_IU
          && bus.resolve_warpID_SIMT_IU == LW'(w)
          && state_q[w] == W_BR_WAIT:
          state_d[w] = W_ACTIVE;
        default: ;
      endcase
    end
  end

  always_comb begin
    rr_ptr_d = gvld ? nxt_ptr(gidx) : rr_ptr_q;
    valid_d  = gvld;
    oc_id_d  = gvld ? gidx : '0;
    exit_d   = gvld & bus.exit_IB_IU[gidx];
    rau_id_d = exit_d ? gidx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < N; w++)
        state_q[w] <= W_IDLE;
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      oc_id_q  <= '0;
      exit_q   <= 1'b0;
      rau_id_q <= '0;
    end else begin
      for (int w = 0; w < N; w++)
        state_q[w] <= state_d[w];
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      oc_id_q  <= oc_id_d;
      exit_q   <= exit_d;
      rau_id_q <= rau_id_d;
    end
  end

  assign bus.valid_IU_OC   = valid_q;
  assign bus.warpID_IU_OC  = oc_id_q;
  assign bus.exit_IU_RAU   = exit_q;
  assign bus.warpID_IU_RAU = rau_id_q;

endmodule

// File: tb/tb_iu_warp_scheduler.sv
// Bench for iu_warp_scheduler: directed table,
// corner sequences and random vs. a warp model.
module tb_iu_warp_scheduler;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iu_warp_scheduler_if ifc ();

  iu_warp_scheduler #(
    .NUM_WARPS    (8),
    .LOGNUM_WARPS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct {
    bit       r;
    bit       st;
    int       sid;
    bit       rs;
    int       rid;
    bit [7:0] req;
    bit [7:0] rdy;
    bit [7:0] br;
    bit [7:0] ex;
    bit       full;
    int       eg;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // model: 0 idle, 1 active, 2 waiting on branch
  int ms [N];
  int mptr;
  bit mvalid, mexit, mclr;
  int mwid, mrid;

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, a, e, $time);
    end
  endtask

  task automatic step(bit r, bit st, int sid,
                      bit rs, int rid,
                      bit [7:0] req, bit [7:0] rdy,
                      bit [7:0] br, bit [7:0] ex,
                      bit full, int eg);
    int g;
    int k;
    int old [N];
    bit [7:0] egv;
    rst = r;
    ifc.start_RAU_IU = st;
    ifc.start_warpID_RAU_IU = 3'(sid);
    ifc.resolve_SIMT_IU = rs;
    ifc.resolve_warpID_SIMT_IU = 3'(rid);
    ifc.req_IB_IU = req;
    ifc.ready_SB_IU = rdy;
    ifc.branch_IB_IU = br;
    ifc.exit_IB_IU = ex;
    ifc.full_OC_IU = full;
    @(negedge clk);
    g = -1;
    if (!r && !full)
      for (int i = 0; i < N; i++) begin
        k = (mptr + i) % N;
        if (g < 0 && ms[k] == 1 && req[k] && rdy[k])
          g = k;
      end
    egv = (g < 0) ? 8'h00 : 8'(1 << g);
    chk("grant", 32'(ifc.grt_IU_IB), 32'(egv));
    if (eg >= 0)
      chk("vec_grant", 32'(ifc.grt_IU_IB), eg);
    chk("valid_oc", 32'(ifc.valid_IU_OC), 32'(mvalid));
    if (mvalid || mclr)
      chk("warpid_oc", 32'(ifc.warpID_IU_OC), mwid);
    chk("exit_rau", 32'(ifc.exit_IU_RAU), 32'(mexit));
    if (mexit || mclr)
      chk("warpid_rau", 32'(ifc.warpID_IU_RAU), mrid);
    for (int i = 0; i < N; i++) old[i] = ms[i];
    if (r) begin
      for (int i = 0; i < N; i++) ms[i] = 0;
      mptr = 0; mvalid = 0; mexit = 0;
      mwid = 0; mrid = 0; mclr = 1;
    end else begin
      mclr = 0;
      mvalid = (g >= 0);
      mexit = 0;
      if (g >= 0) begin
        mwid = g;
        mptr = (g + 1) % N;
        if (ex[g]) begin
          ms[g] = 0; mexit = 1; mrid = g;
        end else if (br[g]) ms[g] = 2;
      end
      if (st && old[sid] == 0) ms[sid] = 1;
      if (rs && old[rid] == 2) ms[rid] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit r, bit st, int sid,
      bit [7:0] req, bit full, int eg);
    vec_t v;
    v.r = r; v.st = st; v.sid = sid;
    v.rs = 0; v.rid = 0;
    v.req = req; v.rdy = req;
    v.br = 0; v.ex = 0;
    v.full = full; v.eg = eg;
    return v;
  endfunction

  task automatic rs_step();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t tbl [19];

  initial begin
    for (int i = 0; i < N; i++) ms[i] = 0;
    mptr = 0; mvalid = 0; mexit = 0;
    mwid = 0; mrid = 0; mclr = 1;

    tbl[0]  = mk(1, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 0, 0, 8'h00, 0, 0);
    tbl[2]  = mk(0, 1, 0, 8'h00, 0, 0);
    tbl[3]  = mk(0, 1, 1, 8'h00, 0, 0);
    tbl[4]  = mk(0, 1, 2, 8'h00, 0, 0);
    tbl[5]  = mk(0, 1, 3, 8'h00, 0, 0);
    tbl[6]  = mk(0, 0, 0, 8'h0f, 0, 8'h01);
    tbl[7]  = mk(0, 0, 0, 8'h0f, 0, 8'h02);
    tbl[8]  = mk(0, 0, 0, 8'h0f, 0, 8'h04);
    tbl[9]  = mk(0, 0, 0, 8'h0f, 0, 8'h08);
    tbl[10] = mk(0, 0, 0, 8'h0f, 0, 8'h01);
    tbl[11] = mk(1, 0, 0, 8'h0f, 0, 0);
    tbl[12] = mk(0, 1, 0, 8'h00, 0, 0);
    tbl[13] = mk(0, 1, 1, 8'h00, 0, 0);
    tbl[14] = mk(0, 0, 0, 8'h03, 1, 0);
    tbl[15] = mk(0, 0, 0, 8'h03, 1, 0);
    tbl[16] = mk(0, 0, 0, 8'h03, 1, 0);
    tbl[17] = mk(0, 0, 0, 8'h03, 0, 8'h01);
    tbl[18] = mk(0, 0, 0, 8'h03, 0, 8'h02);

    rst = 1'b1;
    for (int i = 0; i < 19; i++)
      step(tbl[i].r, tbl[i].st, tbl[i].sid,
           tbl[i].rs, tbl[i].rid, tbl[i].req,
           tbl[i].rdy, tbl[i].br, tbl[i].ex,
           tbl[i].full, tbl[i].eg);

    // branch parks warp 2 until resolved
    rs_step();
    step(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h04, 8'h04, 8'h04, 0, 0, 8'h04);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 8'h04, 8'h04, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 8'h04, 8'h04, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h04, 8'h04, 0, 0, 0, 8'h04);

    // exit retires warp 5 until restarted
    rs_step();
    step(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h20, 8'h20, 0, 8'h20, 0, 8'h20);
    chk("exit_now", 32'(ifc.exit_IU_RAU), 1);
    chk("exit_id", 32'(ifc.warpID_IU_RAU), 5);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 5, 8'h20, 8'h20, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0, 8'h20, 8'h20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h20, 8'h20, 0, 0, 0, 8'h20);

    // branch+exit together: exit wins
    rs_step();
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h02, 8'h02, 8'h02, 8'h02, 0, 8'h02);
    step(0, 0, 0, 1, 1, 8'h02, 8'h02, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h02, 8'h02, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 8'h02, 8'h02, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h02, 8'h02, 0, 0, 0, 8'h02);

    // mid-stream reset drops in-flight issue
    rs_step();
    for (int k = 0; k < N; k++)
      step(0, 1, k, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'hff, 8'hff, 0, 0, 0, 8'h01);
    step(0, 0, 0, 0, 0, 8'hff, 8'hff, 0, 0, 0, 8'h02);
    step(0, 0, 0, 0, 0, 8'hff, 8'hff, 0, 8'h04, 0, 8'h04);
    step(1, 0, 0, 0, 0, 8'hff, 8'hff, 0, 0, 0, 0);
    chk("rst_valid", 32'(ifc.valid_IU_OC), 0);
    chk("rst_exit", 32'(ifc.exit_IU_RAU), 0);
    step(0, 0, 0, 0, 0, 8'hff, 8'hff, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 8'hff, 8'hff, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'hff, 8'hff, 0, 0, 0, 8'h08);
    step(0, 0, 0, 0, 0, 8'hff, 8'hff, 0, 0, 0, 8'h01);

    rs_step();
    for (int c = 0; c < 600; c++) begin
      bit [7:0] b, e;
      b = 8'($urandom & $urandom & $urandom);
      e = 8'($urandom & $urandom & $urandom);
      step($urandom_range(0, 99) < 2,
           bit'($urandom % 2), $urandom_range(0, 7),
           bit'($urandom % 2), $urandom_range(0, 7),
           8'($urandom), 8'($urandom | $urandom),
           b, e, $urandom_range(0, 99) < 20, -1);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
